// File: rtl/hpmsampler.sv
// Performance-counter snapshot reader: on a periodic or software trigger, reads each
// enabled counter in ascending order and streams a framed packet on a valid/ready port.
module hpmsampler #(
  parameter int unsigned COUNTERS = 32,
  parameter int unsigned PERIODW  = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                Enable,
  input  logic [PERIODW-1:0]  PeriodCycles,
  input  logic                TriggerM,
  input  logic [COUNTERS-1:0] SampleMask,
  output logic                CntReqValid,
  output logic [4:0]          CntReqNum,
  input  logic                CntRspValid,
  input  logic [63:0]         CntRspData,
  output logic                OutValid,
  input  logic                OutReady,
  output logic [63:0]         OutData,
  output logic                OutLast,
  output logic                Busy,
  output logic [15:0]         DroppedCount
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HDR  = 3'd1;
  localparam logic [2:0] S_REQ  = 3'd2;
  localparam logic [2:0] S_WAIT = 3'd3;
  localparam logic [2:0] S_DATA = 3'd4;

  logic [2:0]          state_q, state_d;
  logic [COUNTERS-1:0] mask_q, mask_d;
  logic [4:0]          cur_q, cur_d;
  logic [15:0]         seq_q, seq_d;
  logic [15:0]         drop_q, drop_d;
  logic [PERIODW-1:0]  timer_q, timer_d;
  logic [63:0]         odata_q, odata_d;
  logic                ovalid_q, ovalid_d;
  logic                olast_q, olast_d;

  logic                period_run, period_fire, trigger, handshake, found;
  logic [4:0]          low_idx;
  logic [COUNTERS-1:0] mask_clr;
  logic [31:0]         hdr_mask;

  assign period_run  = Enable && (PeriodCycles != '0);
  // >= rather than == so that shrinking the period mid-count fires on the next cycle
  assign period_fire = period_run && (timer_q >= (PeriodCycles - PERIODW'(1)));
  assign trigger     = Enable && (TriggerM || period_fire);
  assign handshake   = ovalid_q && OutReady;

  always_comb begin
    low_idx = '0;
    found   = 1'b0;
    for (int unsigned i = 0; i < COUNTERS; i++) begin
      if (mask_q[i] && !found) begin
        low_idx = 5'(i);
        found   = 1'b1;
      end
    end
  end

  always_comb begin
    mask_clr        = mask_q;
    mask_clr[cur_q] = 1'b0;
    hdr_mask        = '0;
    hdr_mask[COUNTERS-1:0] = SampleMask;
  end

  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    cur_d    = cur_q;
    seq_d    = seq_q;
    drop_d   = drop_q;
    odata_d  = odata_q;
    ovalid_d = ovalid_q;
    olast_d  = olast_q;
    timer_d  = (!period_run || period_fire) ? '0 : timer_q + PERIODW'(1);

    if (trigger && (state_q != S_IDLE) && (drop_q != 16'hFFFF))
      drop_d = drop_q + 16'd1;

    case (state_q)
      S_IDLE: begin
        if (trigger) begin
          mask_d   = SampleMask;
          seq_d    = seq_q + 16'd1;
          odata_d  = {16'hC5A1, seq_q, hdr_mask};
          ovalid_d = 1'b1;
          olast_d  = (SampleMask == '0);
          state_d  = S_HDR;
        end
      end
      S_HDR, S_DATA: begin
        if (handshake) begin
          ovalid_d = 1'b0;
          olast_d  = 1'b0;
          state_d  = (mask_q != '0) ? S_REQ : S_IDLE;
        end
      end
      S_REQ: begin
        cur_d   = low_idx;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (CntRspValid) begin
          mask_d   = mask_clr;
          odata_d  = CntRspData;
          ovalid_d = 1'b1;
          olast_d  = (mask_clr == '0);
          state_d  = S_DATA;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      mask_q   <= '0;
      cur_q    <= '0;
      seq_q    <= '0;
      drop_q   <= '0;
      timer_q  <= '0;
      odata_q  <= '0;
      ovalid_q <= 1'b0;
      olast_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      cur_q    <= cur_d;
      seq_q    <= seq_d;
      drop_q   <= drop_d;
      timer_q  <= timer_d;
      odata_q  <= odata_d;
      ovalid_q <= ovalid_d;
      olast_q  <= olast_d;
    end
  end

  assign CntReqValid  = (state_q == S_REQ);
  assign CntReqNum    = (state_q == S_REQ) ? low_idx : '0;
  assign OutValid     = ovalid_q;
  assign OutData      = odata_q;
  assign OutLast      = olast_q;
  assign Busy         = (state_q != S_IDLE);
  assign DroppedCount = drop_q;

endmodule

// File: tb/tb_hpmsampler.sv
// Directed bench for hpmsampler: expected packet words and request numbers are queued
// by the stimulus and checked by an independent monitor at each handshake.
module tb_hpmsampler;

  logic        clk = 1'b0;
  logic        reset;
  logic        Enable;
  logic [31:0] PeriodCycles;
  logic        TriggerM;
  logic [31:0] SampleMask;
  logic        CntReqValid;
  logic [4:0]  CntReqNum;
  logic        CntRspValid;
  logic [63:0] CntRspData;
  logic        OutValid;
  logic        OutReady;
  logic [63:0] OutData;
  logic        OutLast;
  logic        Busy;
  logic [15:0] DroppedCount;

  int errors = 0;
  int checks = 0;

  logic [64:0] exp_q[$];
  logic [4:0]  req_q[$];
  logic        resp_en = 1'b1;
  logic        inject_rsp = 1'b0;

  hpmsampler #(.COUNTERS(32), .PERIODW(32)) dut (
    .clk(clk), .reset(reset), .Enable(Enable), .PeriodCycles(PeriodCycles),
    .TriggerM(TriggerM), .SampleMask(SampleMask), .CntReqValid(CntReqValid),
    .CntReqNum(CntReqNum), .CntRspValid(CntRspValid), .CntRspData(CntRspData),
    .OutValid(OutValid), .OutReady(OutReady), .OutData(OutData), .OutLast(OutLast),
    .Busy(Busy), .DroppedCount(DroppedCount)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] rsp_value(input logic [4:0] n);
    if (n == 5'd0) return 64'h10;
    if (n == 5'd2) return 64'h20;
    return 64'hA000 + 64'(n);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_trigger();
    TriggerM = 1'b1;
    tick();
    TriggerM = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int unsigned k = 0;
    while ((Busy || exp_q.size() != 0 || req_q.size() != 0) && k < 300) begin
      tick();
      k++;
    end
    chk({name, "_timeout"}, 64'(k >= 300), 64'd0);
  endtask

  // Counter-file model: answers a request one cycle later, or injects a stray strobe
  initial begin
    logic       pend;
    logic [4:0] n;
    pend = 1'b0;
    n = '0;
    CntRspValid = 1'b0;
    CntRspData  = '0;
    forever begin
      @(negedge clk);
      if (CntReqValid && resp_en) begin
        pend = 1'b1;
        n = CntReqNum;
      end
      @(posedge clk);
      #2;
      CntRspValid = pend || inject_rsp;
      CntRspData  = pend ? rsp_value(n) : 64'hDEAD_BEEF_0000_0001;
      pend = 1'b0;
    end
  end

  // Monitor: compares each handshaken word and each request against the queues
  initial begin
    logic        stalled;
    logic [63:0] held;
    logic [64:0] e;
    logic [4:0]  r;
    stalled = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (stalled && OutValid)
        chk("out_hold", OutData, held);
      if (OutValid && OutReady) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", OutData, 64'hX);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", OutData, e[63:0]);
          chk("out_last", 64'(OutLast), 64'(e[64]));
        end
      end
      if (CntReqValid) begin
        if (req_q.size() == 0) begin
          chk("unexpected_req", 64'(CntReqNum), 64'hX);
        end else begin
          r = req_q.pop_front();
          chk("req_num", 64'(CntReqNum), 64'(r));
        end
      end
      stalled = OutValid && !OutReady;
      held = OutData;
    end
  end

  initial begin
    reset = 1'b0;
    Enable = 1'b0;
    PeriodCycles = '0;
    TriggerM = 1'b0;
    SampleMask = '0;
    OutReady = 1'b1;
    tick();
    tick();
    chk("rst_outvalid", 64'(OutValid), 64'd0);
    chk("rst_outdata", OutData, 64'd0);
    chk("rst_outlast", 64'(OutLast), 64'd0);
    chk("rst_busy", 64'(Busy), 64'd0);
    chk("rst_dropped", 64'(DroppedCount), 64'd0);
    chk("rst_reqvalid", 64'(CntReqValid), 64'd0);
    chk("rst_reqnum", 64'(CntReqNum), 64'd0);
    reset = 1'b1;
    Enable = 1'b1;
    tick();

    // Two-counter packet
    SampleMask = 32'h5;
    exp_q.push_back({1'b0, 64'hC5A1_0000_0000_0005});
    exp_q.push_back({1'b0, 64'h10});
    exp_q.push_back({1'b1, 64'h20});
    req_q.push_back(5'd0);
    req_q.push_back(5'd2);
    TriggerM = 1'b1;
    chk("busy_trig_cycle", 64'(Busy), 64'd0);
    tick();
    TriggerM = 1'b0;
    chk("busy_after_trig", 64'(Busy), 64'd1);
    wait_done("pkt2");

    // Empty mask: header only
    SampleMask = 32'h0;
    exp_q.push_back({1'b1, 64'hC5A1_0001_0000_0000});
    pulse_trigger();
    chk("empty_busy_t1", 64'(Busy), 64'd1);
    tick();
    chk("empty_busy_t2", 64'(Busy), 64'd0);
    wait_done("empty");

    // Periodic trigger with stalled output: triggers at 9 start, 19 and 29 drop
    OutReady = 1'b0;
    SampleMask = 32'h1;
    exp_q.push_back({1'b0, 64'hC5A1_0002_0000_0001});
    exp_q.push_back({1'b1, 64'h10});
    req_q.push_back(5'd0);
    PeriodCycles = 32'd10;
    repeat (35) tick();
    PeriodCycles = '0;
    chk("period_dropped", 64'(DroppedCount), 64'd2);
    chk("period_busy", 64'(Busy), 64'd1);
    OutReady = 1'b1;
    wait_done("period");

    // Software trigger coincident with period expiry
    SampleMask = 32'h0;
    exp_q.push_back({1'b1, 64'hC5A1_0003_0000_0000});
    PeriodCycles = 32'd4;
    repeat (3) tick();
    TriggerM = 1'b1;
    tick();
    TriggerM = 1'b0;
    PeriodCycles = '0;
    wait_done("coincide");
    repeat (4) tick();
    chk("coincide_dropped", 64'(DroppedCount), 64'd2);
    chk("coincide_idle", 64'(Busy), 64'd0);

    // Saturation of the drop counter
    OutReady = 1'b0;
    SampleMask = 32'h1;
    exp_q.push_back({1'b0, 64'hC5A1_0004_0000_0001});
    exp_q.push_back({1'b1, 64'h10});
    req_q.push_back(5'd0);
    TriggerM = 1'b1;
    repeat (65540) tick();
    TriggerM = 1'b0;
    tick();
    chk("sat_dropped", 64'(DroppedCount), 64'hFFFF);
    chk("sat_busy", 64'(Busy), 64'd1);
    OutReady = 1'b1;
    wait_done("sat");
    chk("sat_hold", 64'(DroppedCount), 64'hFFFF);

    // Reset while waiting for a counter response
    resp_en = 1'b0;
    exp_q.push_back({1'b0, 64'hC5A1_0005_0000_0001});
    req_q.push_back(5'd0);
    pulse_trigger();
    tick();
    chk("wait_reqvalid", 64'(CntReqValid), 64'd1);
    tick();
    reset = 1'b0;
    #1;
    chk("rstmid_outvalid", 64'(OutValid), 64'd0);
    chk("rstmid_reqvalid", 64'(CntReqValid), 64'd0);
    chk("rstmid_busy", 64'(Busy), 64'd0);
    chk("rstmid_dropped", 64'(DroppedCount), 64'd0);
    tick();
    reset = 1'b1;
    resp_en = 1'b1;
    inject_rsp = 1'b1;
    tick();
    inject_rsp = 1'b0;
    tick();
    tick();
    chk("late_rsp_outvalid", 64'(OutValid), 64'd0);
    chk("late_rsp_busy", 64'(Busy), 64'd0);

    // Sequence number restarts after reset
    SampleMask = 32'h0;
    exp_q.push_back({1'b1, 64'hC5A1_0000_0000_0000});
    pulse_trigger();
    wait_done("post_reset");
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
